ntt_stage_scheduler: RTL and testbench
======================================

Name: ntt_stage_scheduler

Overview:
- Sequences a full forward in-place radix-2 Cooley-Tukey NTT over one N=2^LOG_N coefficient memory through a single pipelined CT butterfly.
- Generates per-butterfly read addresses (a, b) and twiddle index, then the matching write-back addresses after the fixed read + butterfly latency.
- Inserts drain gaps between stages so no read precedes a pending write.
- Sits between the top-level NTT control (start/done) and the coefficient RAM / twiddle ROM / ct_butterfly datapath.

Parameters:
- LOG_N, 3, log2 of transform size; N=2^LOG_N, N/2 butterflies per stage, LOG_N stages.
- MEM_LAT, 1, cycles from rd_en/address to RAM and ROM data valid at the butterfly inputs.
- BF_LATENCY, 6, ct_butterfly input-to-A/B latency in cycles.
- Derived: L = MEM_LAT + BF_LATENCY, the issue-to-write-back distance.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin transform; sampled only in IDLE.
- hold  in  1  pause issuing new butterflies; honoured only in ISSUE.
- busy  out  1  high from the first cycle after accepted start until done.
- done  out  1  one-cycle pulse when the last write-back has completed.
- stage  out  LOG_N  current stage index, 0..LOG_N-1.
- rd_en  out  1  issue strobe for one butterfly.
- rd_addr_a  out  LOG_N  address of operand a.
- rd_addr_b  out  LOG_N  address of operand b.
- tw_addr  out  LOG_N  twiddle ROM index (bit-reversed psi table).
- wr_en  out  1  write-back strobe, rd_en delayed by exactly L cycles.
- wr_addr_a  out  LOG_N  destination of butterfly output A (equals rd_addr_a delayed L).
- wr_addr_b  out  LOG_N  destination of butterfly output B (equals rd_addr_b delayed L).

Behaviour:
- Reset: state IDLE; busy, done, rd_en, wr_en = 0; stage, all address outputs, and counters = 0. The delay line is cleared, so in-flight write-backs are discarded (wr_en stays 0).
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: on start=1, clear stage and butterfly counter k, go to ISSUE. Busy rises on the next cycle.
- ISSUE: each cycle with hold=0, assert rd_en and increment k (0..N/2-1).
  - t = N >> (stage+1).
  - group = k >> (LOG_N-1-stage); offset = k & (t-1).
  - rd_addr_a = group*2t + offset; rd_addr_b = rd_addr_a + t.
  - tw_addr = 2^stage + group.
  - All outputs are registered, with the same timing as rd_en.
  - hold=1 in ISSUE: rd_en=0, k frozen, address outputs hold their last value; the delay line keeps shifting.
  - After issuing k = N/2-1, go to DRAIN.
- DRAIN: exactly L cycles, with no rd_en and hold ignored.
  - Last issue at cycle c: its wr_en is at c+L, and the next stage's first rd_en is at c+L+1.
  - At the end of DRAIN: if stage < LOG_N-1, increment stage, set k=0, and return to ISSUE; otherwise go to DONE.
- DONE: done=1 and busy=0 for one cycle, then IDLE. A start in this cycle is ignored.
- Delay line: an L-deep shift register of {rd_en, rd_addr_a, rd_addr_b} produces wr_en/wr_addr_a/wr_addr_b. It is independent of FSM state.
- start while busy: ignored.
- No two write-backs of the same stage target the same address. wr_en never overlaps a rd_en of the following stage.
- All arithmetic is unsigned, LOG_N bits wide. No wrap occurs for valid k and stage.

Optional Feature:
- Macro NTT_SCHED_PERF_EN.
- Defined: adds output perf_cycles (32 bits).
  - Cleared on accepted start.
  - Increments on every cycle busy=1, including hold and drain cycles.
  - Holds its value after done until the next start; reset to 0.
- Undefined: the port and counter are absent; the rest of the behaviour is identical.

Test Plan:
- Defaults (LOG_N=3, L=7), start pulse at cycle 0.
  - rd_en high at cycles 1-4, 12-15, 23-26.
  - wr_en high at cycles 8-11, 19-22, 30-33.
  - done pulses at cycle 34.
  - busy high for cycles 1-33.
- Address check, same run:
  - Stage 0: (a,b,tw) = (0,4,1),(1,5,1),(2,6,1),(3,7,1).
  - Stage 1: (0,2,2),(1,3,2),(4,6,3),(5,7,3).
  - Stage 2: (0,1,4),(2,3,5),(4,5,6),(6,7,7).
  - wr_addr_a/b must equal each pair 7 cycles later.
- Hold: assert hold during cycles 2-3 of stage 0.
  - rd_en pattern becomes 1,0,0,1,1,1 over cycles 1-6.
  - Every later event shifts +2; done at cycle 36.
  - A hold asserted during DRAIN causes no shift.
- Reset mid-run: drop rst_n at cycle 14.
  - All outputs go to 0 immediately, with no wr_en afterward.
  - A new start after release reproduces the first scenario.
- start held high throughout: exactly one transform per IDLE entry; done pulses at 34, the next run begins with rd_en at cycle 36.
- NTT_SCHED_PERF_EN defined: perf_cycles=33 after the first scenario and 35 after the hold scenario; cleared on the next accepted start.

Source files
------------

// File: rtl/ntt_stage_scheduler_if.sv
// Memory-side bundle of the NTT stage scheduler. It carries the read, twiddle
// and write-back strobes and addresses that go to the coefficient RAM, the
// twiddle ROM and the butterfly datapath.
interface ntt_stage_scheduler_if #(
  parameter int unsigned LOG_N = 3
);
  logic             rd_en;
  logic [LOG_N-1:0] rd_addr_a;
  logic [LOG_N-1:0] rd_addr_b;
  logic [LOG_N-1:0] tw_addr;
  logic             wr_en;
  logic [LOG_N-1:0] wr_addr_a;
  logic [LOG_N-1:0] wr_addr_b;

  modport master (
    output rd_en, rd_addr_a, rd_addr_b, tw_addr,
    output wr_en, wr_addr_a, wr_addr_b
  );

  modport slave (
    input rd_en, rd_addr_a, rd_addr_b, tw_addr,
    input wr_en, wr_addr_a, wr_addr_b
  );
endinterface

// File: rtl/ntt_stage_scheduler.sv
// Address and strobe sequencer for a forward in-place radix-2 Cooley-Tukey NTT
// built around one pipelined butterfly. It issues N/2 butterflies per stage,
// then drains for L = MEM_LAT + BF_LATENCY cycles so that the next stage never
// reads a word whose write-back is still pending. Write-back strobes and
// addresses are the issue strobes and addresses delayed by exactly L cycles.
// Optional macro NTT_SCHED_PERF_EN adds o_perf_cycles, a count of busy cycles.
module ntt_stage_scheduler #(
  parameter int unsigned LOG_N      = 3,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned BF_LATENCY = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_hold,
  output logic             o_busy,
  output logic             o_done,
  output logic [LOG_N-1:0] o_stage,
`ifdef NTT_SCHED_PERF_EN
  output logic [31:0]      o_perf_cycles,
`endif
  ntt_stage_scheduler_if.master mem
);

  localparam int unsigned      L          = MEM_LAT + BF_LATENCY;
  localparam int unsigned      DW         = $clog2(L + 1);
  localparam logic [LOG_N-1:0] ONE        = LOG_N'(1);
  localparam logic [LOG_N-1:0] HALF_N     = ONE << (LOG_N - 1);
  localparam logic [LOG_N-1:0] LAST_K     = HALF_N - ONE;
  localparam logic [LOG_N-1:0] LAST_STAGE = LOG_N'(LOG_N - 1);
  localparam logic [DW-1:0]    DRAIN_LAST = DW'(L);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t           r_state;
  logic [LOG_N-1:0] r_stage;
  logic [LOG_N-1:0] r_k;
  logic [DW-1:0]    r_dcnt;
  logic             r_busy;
  logic             r_done;
  logic             r_rd_en;
  logic [LOG_N-1:0] r_rd_a;
  logic [LOG_N-1:0] r_rd_b;
  logic [LOG_N-1:0] r_tw;

  logic             r_dl_en [L];
  logic [LOG_N-1:0] r_dl_a  [L];
  logic [LOG_N-1:0] r_dl_b  [L];

  logic             w_issue;
  logic [LOG_N-1:0] w_iss_stage;
  logic [LOG_N-1:0] w_iss_k;
  logic [LOG_N-1:0] w_sh;
  logic [LOG_N-1:0] w_t;
  logic [LOG_N-1:0] w_group;
  logic [LOG_N-1:0] w_off;
  logic [LOG_N-1:0] w_a;
  logic [LOG_N-1:0] w_b;
  logic [LOG_N-1:0] w_tw;

  // Select which (stage, k) is issued on the coming edge and derive its addresses.
  // The first butterfly of a stage issues on the same edge that accepts start
  // or ends the drain, so its coordinates are muxed rather than read from r_k.
  always_comb begin
    w_issue     = 1'b0;
    w_iss_stage = r_stage;
    w_iss_k     = r_k;
    case (r_state)
      S_IDLE: begin
        w_issue     = i_start;
        w_iss_stage = '0;
        w_iss_k     = '0;
      end
      S_ISSUE: begin
        w_issue = !i_hold;
      end
      S_DRAIN: begin
        w_issue     = (r_dcnt == DRAIN_LAST) && (r_stage != LAST_STAGE);
        w_iss_stage = r_stage + ONE;
        w_iss_k     = '0;
      end
      default: begin
        w_issue = 1'b0;
      end
    endcase
    w_sh    = LAST_STAGE - w_iss_stage;
    w_t     = HALF_N >> w_iss_stage;
    w_group = w_iss_k >> w_sh;
    w_off   = w_iss_k & (w_t - ONE);
    // group * 2t == (group << 1) << (LOG_N-1-stage); no bits are lost for valid k
    w_a     = ((w_group << 1) << w_sh) + w_off;
    w_b     = w_a + w_t;
    w_tw    = (ONE << w_iss_stage) + w_group;
  end

  // Control FSM with registered busy/done/stage and issue outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_stage <= '0;
      r_k     <= '0;
      r_dcnt  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rd_en <= 1'b0;
      r_rd_a  <= '0;
      r_rd_b  <= '0;
      r_tw    <= '0;
    end else begin
      r_done  <= 1'b0;
      r_rd_en <= w_issue;
      if (r_state == S_IDLE && i_start) begin
        r_busy <= 1'b1;
      end
      if (w_issue) begin
        r_stage <= w_iss_stage;
        r_rd_a  <= w_a;
        r_rd_b  <= w_b;
        r_tw    <= w_tw;
        if (w_iss_k == LAST_K) begin
          r_state <= S_DRAIN;
          r_dcnt  <= '0;
        end else begin
          r_state <= S_ISSUE;
          r_k     <= w_iss_k + ONE;
        end
      end else begin
        case (r_state)
          S_DRAIN: begin
            if (r_dcnt == DRAIN_LAST) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_dcnt <= r_dcnt + DW'(1);
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
          end
          default: begin
          end
        endcase
      end
    end
  end

  // L-deep delay line turning issue strobes/addresses into write-back ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < L; i++) begin
        r_dl_en[i] <= 1'b0;
        r_dl_a[i]  <= '0;
        r_dl_b[i]  <= '0;
      end
    end else begin
      r_dl_en[0] <= r_rd_en;
      r_dl_a[0]  <= r_rd_a;
      r_dl_b[0]  <= r_rd_b;
      for (int unsigned i = 1; i < L; i++) begin
        r_dl_en[i] <= r_dl_en[i-1];
        r_dl_a[i]  <= r_dl_a[i-1];
        r_dl_b[i]  <= r_dl_b[i-1];
      end
    end
  end

`ifdef NTT_SCHED_PERF_EN
  logic [31:0] r_perf;

  // Busy-cycle counter, cleared when a transform is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf <= '0;
    end else if (r_state == S_IDLE && i_start) begin
      r_perf <= '0;
    end else if (r_busy) begin
      r_perf <= r_perf + 32'd1;
    end
  end

  assign o_perf_cycles = r_perf;
`endif

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_stage       = r_stage;
  assign mem.rd_en     = r_rd_en;
  assign mem.rd_addr_a = r_rd_a;
  assign mem.rd_addr_b = r_rd_b;
  assign mem.tw_addr   = r_tw;
  assign mem.wr_en     = r_dl_en[L-1];
  assign mem.wr_addr_a = r_dl_a[L-1];
  assign mem.wr_addr_b = r_dl_b[L-1];

endmodule

// File: tb/tb_ntt_stage_scheduler.sv
// Directed bench for ntt_stage_scheduler (LOG_N=3, L=7). Cycle n is the clock
// period following the n-th rising edge after the start-driving edge; outputs
// are sampled on the falling edge.
`timescale 1ns/1ps
module tb_ntt_stage_scheduler;
  localparam int unsigned LOG_N = 3;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       hold  = 1'b0;
  logic       busy;
  logic       done;
  logic [2:0] stage;
`ifdef NTT_SCHED_PERF_EN
  logic [31:0] perf;
`endif

  ntt_stage_scheduler_if #(.LOG_N(LOG_N)) mem_if ();

  ntt_stage_scheduler #(.LOG_N(LOG_N), .MEM_LAT(1), .BF_LATENCY(6)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (start),
    .i_hold        (hold),
    .o_busy        (busy),
    .o_done        (done),
    .o_stage       (stage),
`ifdef NTT_SCHED_PERF_EN
    .o_perf_cycles (perf),
`endif
    .mem           (mem_if)
  );

  always #5 clk = ~clk;

  // One butterfly: issue cycle without / with the stage-0 hold, and its outputs.
  typedef struct {
    int         c_plain;
    int         c_hold;
    logic [2:0] stg;
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] tw;
  } bf_vec_t;

  bf_vec_t    vt [12];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [2:0] m_a, m_b, m_tw;

  task automatic check(input string nm, input int cyc,
                       input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Full transform from an idle DUT; use_hold inserts the stage-0 hold
  // (sampled at edges 2-3) and a hold during the first drain (no effect).
  task automatic run_xform(input bit use_hold);
    int         done_c, last_c;
    logic       een [64];
    logic [2:0] ea [64], eb [64], etw [64], est [64];
    logic [2:0] ca, cb, ct, pre_a, pre_b;
    done_c = use_hold ? 36 : 34;
    last_c = done_c + 3;
    pre_a  = m_a;
    pre_b  = m_b;
    ca = m_a; cb = m_b; ct = m_tw;
    for (int c = 0; c <= last_c; c++) begin
      een[c] = 1'b0;
      est[c] = 3'd0;
      for (int i = 0; i < 12; i++) begin
        if ((use_hold ? vt[i].c_hold : vt[i].c_plain) == c) begin
          een[c] = 1'b1;
          ca = vt[i].a; cb = vt[i].b; ct = vt[i].tw;
          est[c] = vt[i].stg;
        end
      end
      ea[c] = ca; eb[c] = cb; etw[c] = ct;
    end
    m_a = ca; m_b = cb; m_tw = ct;

    @(posedge clk); #1;
    for (int c = 0; c <= last_c; c++) begin
      start = (c == 0);
      hold  = use_hold && ((c >= 1 && c <= 2) || (c >= 8 && c <= 12));
      @(negedge clk);
      check("busy/done", c, {30'd0, busy, done},
            {30'd0, (c >= 1 && c < done_c), (c == done_c)});
      check("rd", c, {mem_if.rd_en, mem_if.rd_addr_a, mem_if.rd_addr_b, mem_if.tw_addr},
            {een[c], ea[c], eb[c], etw[c]});
      if (een[c]) check("stage", c, stage, est[c]);
      if (c >= 7)
        check("wr", c, {mem_if.wr_en, mem_if.wr_addr_a, mem_if.wr_addr_b},
              {een[c-7], ea[c-7], eb[c-7]});
      else
        check("wr", c, {mem_if.wr_en, mem_if.wr_addr_a, mem_if.wr_addr_b},
              {1'b0, pre_a, pre_b});
      @(posedge clk); #1;
    end
    start = 1'b0;
    hold  = 1'b0;
`ifdef NTT_SCHED_PERF_EN
    check("perf", last_c, perf, use_hold ? 32'd35 : 32'd33);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  w;
    bit  seen;
    vt[0]  = '{1,  1,  3'd0, 3'd0, 3'd4, 3'd1};
    vt[1]  = '{2,  4,  3'd0, 3'd1, 3'd5, 3'd1};
    vt[2]  = '{3,  5,  3'd0, 3'd2, 3'd6, 3'd1};
    vt[3]  = '{4,  6,  3'd0, 3'd3, 3'd7, 3'd1};
    vt[4]  = '{12, 14, 3'd1, 3'd0, 3'd2, 3'd2};
    vt[5]  = '{13, 15, 3'd1, 3'd1, 3'd3, 3'd2};
    vt[6]  = '{14, 16, 3'd1, 3'd4, 3'd6, 3'd3};
    vt[7]  = '{15, 17, 3'd1, 3'd5, 3'd7, 3'd3};
    vt[8]  = '{23, 25, 3'd2, 3'd0, 3'd1, 3'd4};
    vt[9]  = '{24, 26, 3'd2, 3'd2, 3'd3, 3'd5};
    vt[10] = '{25, 27, 3'd2, 3'd4, 3'd5, 3'd6};
    vt[11] = '{26, 28, 3'd2, 3'd6, 3'd7, 3'd7};
    m_a = 3'd0; m_b = 3'd0; m_tw = 3'd0;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset", 0, {busy, done, stage, mem_if.rd_en, mem_if.rd_addr_a, mem_if.rd_addr_b,
                       mem_if.tw_addr, mem_if.wr_en, mem_if.wr_addr_a, mem_if.wr_addr_b}, 32'd0);
    rst_n = 1'b1;

    // Plain transform, then the hold scenario
    run_xform(1'b0);
    repeat (10) @(posedge clk);
    run_xform(1'b1);
    repeat (10) @(posedge clk);

    // Reset in the middle of stage 1
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (13) @(posedge clk);
    #2;
    check("pre-reset", 14, {busy, mem_if.rd_en, mem_if.rd_addr_a, mem_if.rd_addr_b},
          {1'b1, 1'b1, 3'd4, 3'd6});
    rst_n = 1'b0;
    #1;
    check("reset-async", 14, {busy, done, stage, mem_if.rd_en, mem_if.rd_addr_a, mem_if.rd_addr_b,
                              mem_if.tw_addr, mem_if.wr_en, mem_if.wr_addr_a, mem_if.wr_addr_b}, 32'd0);
`ifdef NTT_SCHED_PERF_EN
    check("perf-reset", 14, perf, 32'd0);
`endif
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check("post-reset quiet", c, {mem_if.wr_en, mem_if.rd_en, busy}, 32'd0);
    end
    m_a = 3'd0; m_b = 3'd0; m_tw = 3'd0;
    run_xform(1'b0);
    repeat (10) @(posedge clk);

    // start held high: one transform per IDLE entry
    @(posedge clk); #1 start = 1'b1;
    for (int c = 0; c <= 40; c++) begin
      @(negedge clk);
      check("start-held", c, {29'd0, mem_if.rd_en, busy, done},
            {29'd0,
             ((c >= 1 && c <= 4) || (c >= 12 && c <= 15) || (c >= 23 && c <= 26) || (c >= 36 && c <= 39)),
             ((c >= 1 && c <= 33) || (c >= 36)),
             (c == 34)});
`ifdef NTT_SCHED_PERF_EN
      if (c == 36) check("perf-clear", c, perf, 32'd0);
`endif
      @(posedge clk); #1;
    end
    start = 1'b0;
    seen  = 1'b0;
    for (w = 0; w < 60; w++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("rerun-done seen", 41 + w, {31'd0, seen}, 32'd1);
    check("rerun-done cycle", 41 + w, w, 32'd28);
`ifdef NTT_SCHED_PERF_EN
    check("perf-rerun", 41 + w, perf, 32'd33);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
